// File: rtl/riscv_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package riscv_pkg;

   // Arbiter ownership of the single memory port
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arbState_t;

   localparam int DEF_MAX_WAIT = 4;
   localparam int DEF_TIMEOUT  = 15;

   // Bits needed to hold values 0..maxVal (at least one bit)
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a limit flag.
// Latency: count updates one cycle after inc/clr; atLimit is combinational from the count.
// Backpressure: none; holds at LIMIT while inc stays high.
module sat_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic atLimit
);

   localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

   logic [WIDTH-1:0] count;

   // Clear has priority; increment stops at the limit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != LIM)) begin
         count <= count + WIDTH'(1);
      end
   end

   assign atLimit = (count == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory; data wins unless fetch is starved.
// Latency: grant -> mem_req next cycle; mem_ack -> valid pulse next cycle; one idle turnaround between ops.
// Backpressure: requesters are stalled until their valid pulse; a missing mem_ack times out and sets err.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = DEF_MAX_WAIT,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              stall_if,
   output logic              stall_d,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   localparam int WAIT_W  = cntWidth(MAX_WAIT);
   localparam int TIMER_W = cntWidth(TIMEOUT - 1);

   arbState_t state;

   logic idleFree;
   logic grantData;
   logic grantFetch;
   logic busy;
   logic fetchStarved;
   logic timerAtLimit;
   logic timeout;
   logic waitInc;
   logic waitClr;
   logic timerInc;
   logic timerClr;

   // While a valid pulse is out the requester still presents the finished request,
   // so that cycle is a turnaround and nothing is granted.
   assign idleFree   = (state == IDLE) && !if_valid && !d_valid;
   assign grantData  = idleFree && d_req && !(if_req && fetchStarved);
   assign grantFetch = idleFree && if_req && !grantData;
   assign busy       = (state != IDLE);

   // Timer sits at TIMEOUT-1 during the TIMEOUT-th busy cycle; an ack in that cycle still wins
   assign timeout    = busy && timerAtLimit && !mem_ack;

   // Fetch starvation counts only while the fetch is waiting, not while it is being served
   assign waitInc    = if_req && !grantFetch && (state != BUSY_I) && !if_valid;
   assign waitClr    = grantFetch || !if_req;

   assign timerInc   = busy && !mem_ack;
   assign timerClr   = !busy || mem_ack || timeout;

   assign stall_if   = if_req && !if_valid;
   assign stall_d    = d_req && !d_valid;

   sat_counter #(
      .WIDTH (WAIT_W),
      .LIMIT (MAX_WAIT)
   ) u_waitCnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (waitInc),
      .clr     (waitClr),
      .atLimit (fetchStarved)
   );

   sat_counter #(
      .WIDTH (TIMER_W),
      .LIMIT (TIMEOUT - 1)
   ) u_ackTimer (
      .clk     (clk),
      .rst     (rst),
      .inc     (timerInc),
      .clr     (timerClr),
      .atLimit (timerAtLimit)
   );

   // Arbiter FSM with registered memory request, completion pulses and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_valid  <= 1'b0;
         d_valid   <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         err       <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (grantData) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end else if (grantFetch) begin
                  state     <= BUSY_I;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end
            end
            BUSY_I: begin
               if (mem_ack) begin
                  if_rdata <= mem_rdata;
                  if_valid <= 1'b1;
                  mem_req  <= 1'b0;
                  state    <= IDLE;
               end else if (timeout) begin
                  err      <= 1'b1;
                  if_rdata <= '0;
                  if_valid <= 1'b1;
                  mem_req  <= 1'b0;
                  state    <= IDLE;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  if (!mem_we) begin
                     d_rdata <= mem_rdata;
                  end
                  d_valid <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end else if (timeout) begin
                  err     <= 1'b1;
                  d_rdata <= '0;
                  d_valid <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
